// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, DMA and data-memory port signals around the dmem arbiter.
// master is the arbiter's view; slave is the view of the requesters and memory.
interface dmem_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WIDTH-1:0]  cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [WIDTH-1:0]  cpu_rdata;
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [WIDTH-1:0]  dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [WIDTH-1:0]  dma_rdata;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_w_en, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_w_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: CPU has priority,
// DMA latency is bounded by a starvation counter and burst ownership.
module dmem_arbiter #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 6,
    parameter int MAX_WAIT  = 8,
    parameter int BURST_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.master bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [WW-1:0] MAX_WAIT_C  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BURST_MAX_C = BW'(BURST_MAX);

    localparam logic [0:0] ST_CPU = 1'b0;
    localparam logic [0:0] ST_DMA = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;

    logic [0:0]    state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [1:0]    rd_owner_q, rd_owner_d;
    logic          force_s;
    logic          cpu_gnt_s;
    logic          dma_gnt_s;

    // Grant decision and FSM next state; reset gates every grant to 0.
    always_comb begin
        force_s    = bus.dma_req && (wait_cnt_q >= MAX_WAIT_C);
        cpu_gnt_s  = 1'b0;
        dma_gnt_s  = 1'b0;
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        if (!reset) begin
            force_s    = 1'b0;
            state_d    = ST_CPU;
            beat_cnt_d = BW'(0);
        end else begin
            case (state_q)
                ST_CPU: begin
                    if (bus.cpu_req && !force_s) begin
                        cpu_gnt_s = 1'b1;
                    end else if (bus.dma_req) begin
                        dma_gnt_s = 1'b1;
                        if (BURST_MAX > 1) begin
                            state_d    = ST_DMA;
                            beat_cnt_d = BW'(1);
                        end else begin
                            state_d    = ST_CPU;
                            beat_cnt_d = BW'(0);
                        end
                    end else begin
                        state_d = ST_CPU;
                    end
                end
                ST_DMA: begin
                    if (bus.dma_req && (beat_cnt_q < BURST_MAX_C)) begin
                        dma_gnt_s  = 1'b1;
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end else begin
                        // Hand back to the CPU in this same cycle, ignoring force.
                        state_d    = ST_CPU;
                        beat_cnt_d = BW'(0);
                        if (bus.cpu_req) begin
                            cpu_gnt_s = 1'b1;
                        end else begin
                            cpu_gnt_s = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d    = ST_CPU;
                    beat_cnt_d = BW'(0);
                end
            endcase
        end
    end

    // Starvation counter and read-return ownership for the next cycle.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        rd_owner_d = OWN_NONE;
        if (!bus.dma_req || dma_gnt_s) begin
            wait_cnt_d = WW'(0);
        end else if (wait_cnt_q < MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
        if (cpu_gnt_s && !bus.cpu_we) begin
            rd_owner_d = OWN_CPU;
        end else if (dma_gnt_s && !bus.dma_we) begin
            rd_owner_d = OWN_DMA;
        end else begin
            rd_owner_d = OWN_NONE;
        end
    end

    // Memory port mux driven by whichever requester holds the grant.
    always_comb begin
        bus.mem_w_en  = 1'b0;
        bus.mem_addr  = ADDR_W'(0);
        bus.mem_wdata = WIDTH'(0);
        if (cpu_gnt_s) begin
            bus.mem_w_en  = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (dma_gnt_s) begin
            bus.mem_w_en  = bus.dma_we;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end else begin
            bus.mem_w_en  = 1'b0;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_s;
    assign bus.dma_gnt    = dma_gnt_s;
    assign bus.cpu_stall  = reset && bus.cpu_req && !cpu_gnt_s;
    assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign bus.dma_rvalid = (rd_owner_q == OWN_DMA);
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : WIDTH'(0);
    assign bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : WIDTH'(0);

    // State registers; reset abandons any in-flight read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_CPU;
            wait_cnt_q <= WW'(0);
            beat_cnt_q <= BW'(0);
            rd_owner_q <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            rd_owner_q <= rd_owner_d;
        end
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory (6-bit word address, 32-bit data, 1-cycle read latency) between two requesters. The CPU pipeline MEM stage is the primary requester; a DMA/loader port is the secondary requester. Sits between the memory-access stage and the dmem port. Produces a stall for the CPU while DMA owns the port. Bounds DMA latency with a starvation counter and DMA burst ownership.

Parameters:
WIDTH, 32, data width
ADDR_W, 6, word address width
MAX_WAIT, 8, DMA wait cycles before forced DMA priority (>=1)
BURST_MAX, 4, max consecutive DMA beats per ownership (>=1)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
cpu_req  input  1  CPU access request (level, held until granted)
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU word address
cpu_wdata  input  WIDTH  CPU write data
cpu_gnt  output  1  CPU access accepted this cycle
cpu_stall  output  1  cpu_req & ~cpu_gnt
cpu_rvalid  output  1  CPU read data valid
cpu_rdata  output  WIDTH  CPU read data
dma_req  input  1  DMA access request (level)
dma_we  input  1  DMA write
dma_addr  input  ADDR_W  DMA word address
dma_wdata  input  WIDTH  DMA write data
dma_gnt  output  1  DMA access accepted this cycle
dma_rvalid  output  1  DMA read data valid
dma_rdata  output  WIDTH  DMA read data
mem_w_en  output  1  dmem write enable
mem_addr  output  ADDR_W  dmem address
mem_wdata  output  WIDTH  dmem write data
mem_rdata  input  WIDTH  dmem read data (valid one cycle after address)

Behaviour:
- Reset is asynchronous and active-low. While reset=0: state=ST_CPU, wait_cnt=0, beat_cnt=0, rd_owner=none. All outputs are 0. A reset mid-burst or mid-read abandons the access, and no rvalid follows.
- Grant is combinational in the cycle of the request. At most one of cpu_gnt/dma_gnt is 1. A grant only occurs with the matching req=1.
- Memory port muxing:
  - Granted requester drives mem_addr, mem_wdata, mem_w_en (= that requester's we).
  - No grant: mem_w_en=0, mem_addr=0, mem_wdata=0.
- Read return:
  - A granted read (we=0) sets registered rd_owner. Next cycle, the owner's rvalid=1 and its rdata=mem_rdata.
  - The non-owner's rdata=0. rdata=0 whenever rvalid=0.
  - Writes produce no rvalid.
  - Back-to-back reads give rvalid on consecutive cycles.
- force = dma_req & (wait_cnt >= MAX_WAIT).
- ST_CPU:
  - cpu_req & ~force: cpu_gnt=1. Stay in ST_CPU.
  - Else dma_req: dma_gnt=1, beat_cnt<=1, go to ST_DMA. If BURST_MAX==1, stay in ST_CPU instead.
  - Else: idle.
- ST_DMA:
  - dma_req & beat_cnt<BURST_MAX: dma_gnt=1, beat_cnt++. CPU is stalled.
  - Otherwise: return to ST_CPU, beat_cnt<=0. In the same cycle, apply the ST_CPU rule with force treated as 0 (cpu_gnt if cpu_req). This avoids a dead cycle on handover.
- wait_cnt:
  - Increments when dma_req & ~dma_gnt, saturating at MAX_WAIT.
  - Clears to 0 on dma_gnt or when dma_req=0.
- Simultaneous cpu_req & dma_req in ST_CPU with wait_cnt<MAX_WAIT: CPU wins, and wait_cnt counts.
- cpu_stall = cpu_req & ~cpu_gnt, purely combinational. It is 0 during reset.
- DMA wait is bounded: worst case MAX_WAIT cycles, then the DMA is granted.
- CPU wait is bounded to BURST_MAX cycles, plus 1 cycle on a force grant.

Test Plan:
- Reset/idle:
  - reset=0 with both reqs high: all outputs 0.
  - Release reset, no reqs: mem_w_en=0, no grants.
- CPU read:
  - cpu_req=1, we=0, addr=0x05; mem_rdata=0xDEADBEEF next cycle.
  - Expect cpu_gnt=1 and mem_addr=0x05 in cycle N; cpu_rvalid=1, cpu_rdata=0xDEADBEEF in N+1; dma_rvalid=0.
- Contention/starvation (MAX_WAIT=8):
  - cpu_req and dma_req held high continuously.
  - Expect cpu_gnt for 8 cycles, with wait_cnt reaching 8.
  - 9th cycle: dma_gnt=1, cpu_stall=1.
- DMA burst (BURST_MAX=4):
  - dma_req high 6 cycles with cpu_req high from cycle 2.
  - Expect dma_gnt in cycles 1-4 and cpu_stall=1 in cycles 2-4.
  - Cycle 5: cpu_gnt=1, no dead cycle.
- DMA write then CPU read, same address 0x3F:
  - Expect mem_w_en=1 with dma_wdata=0x12345678 in the DMA cycle.
  - CPU read the following cycle: cpu_rvalid next cycle, no dma_rvalid.
- Reset mid-burst:
  - Drop reset during a DMA burst read.
  - Expect dma_rvalid to stay 0 after reset release and state back to ST_CPU: cpu_req alone is granted immediately.
